mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Sequences the processor's single shared 4K x 16 memory between two requesters: instruction fetch (IF) and operand
//   data (DM). It replaces the bench-side muxing of instruction/data words on M during the processor's operand state.
//   One access in flight at a time; data priority with fetch anti-starvation; fixed, parameterised memory read latency.
// PARAMETERS
//   AW         12  memory address width (word address)
//   DW         16  memory data width
//   RD_LAT     1   cycles from mem_en (read) to mem_rdata valid; legal 1..4
//   STARVE_MAX 4   consecutive DM grants allowed while IF pending before IF is forced; legal 1..15
// PORTS
//   clk        in   1   single clock, all logic on rising edge
//   rst        in   1   synchronous reset, active high
//   if_req     in   1   fetch request; held until if_gnt
//   if_addr    in   AW  fetch address
//   if_gnt     out  1   1-cycle pulse: fetch accepted, issued to memory this cycle
//   if_rvalid  out  1   1-cycle pulse: if_rdata valid
//   if_rdata   out  DW  fetched word; holds last value between pulses
//   dm_req     in   1   data request; held until dm_gnt
//   dm_we      in   1   1 = write, 0 = read
//   dm_addr    in   AW  data address
//   dm_wdata   in   DW  write data
//   dm_gnt     out  1   1-cycle pulse: data request accepted/issued
//   dm_rvalid  out  1   1-cycle pulse: dm_rdata valid (reads only)
//   dm_rdata   out  DW  read word; holds last value between pulses
//   mem_en     out  1   memory access strobe, one cycle per transaction
//   mem_we     out  1   memory write enable, qualified by mem_en
//   mem_addr   out  AW  memory address
//   mem_wdata  out  DW  memory write data
//   mem_rdata  in   DW  memory read data, valid RD_LAT cycles after mem_en
//   busy       out  1   1 whenever state != IDLE
// BEHAVIOUR
//   - Reset: state IDLE, wait/starve counters 0, every output 0 (incl. rdata regs, mem_addr, mem_wdata).
//   - FSM: IDLE -> ACCESS -> (write) IDLE | (read) WAIT -> RESP -> IDLE.
//   - IDLE: if any req, pick winner, latch port id, we, addr, wdata into regs; go ACCESS. No req: stay IDLE.
//   - ACCESS (1 cycle): mem_en=1, mem_we/addr/wdata from latched regs, winner's gnt=1. Read -> WAIT; write -> IDLE.
//   - WAIT: count RD_LAT cycles after ACCESS; on last count capture mem_rdata into winner's rdata reg; -> RESP.
//   - RESP (1 cycle): winner's rvalid=1; -> IDLE. Other port's rdata/rvalid untouched.
//   - Latency (req seen in IDLE at cycle 0): gnt cycle 1; read rvalid at cycle 2+RD_LAT; next IDLE decision cycle
//     3+RD_LAT (read) or 2 (write). IF is always a read; IF has no write path.
//   - mem_en/mem_we are 0 outside ACCESS; mem_addr/mem_wdata hold last latched values.
//   - Arbitration in IDLE: only one req -> that port. Both -> DM, unless starve_cnt == STARVE_MAX -> IF.
//   - starve_cnt: +1 on DM grant while if_req high; cleared on IF grant or on DM grant with if_req low; saturates.
//   - Request inputs sampled only in IDLE; changes during ACCESS/WAIT/RESP ignored. Requester dropping req before
//     gnt is a protocol violation; the latched transaction still completes.
//   - Address passes through unmodified; 0 and 2**AW-1 legal; no wrap or increment logic.
//   - rst in any state: next cycle IDLE with reset outputs; in-flight read discarded, no rvalid, no further mem_en.
//   - No combinational path from any input to any output; gnt/rvalid derive from state regs only.
// TESTING
//   1. rst=1 for 3 cycles with if_req=dm_req=1 -> all outputs 0, busy=0, no mem_en; release -> DM granted cycle 1.
//   2. RD_LAT=1, if_req addr 0xFFF, memory returns 0x5FFF -> if_gnt cycle 1, mem_addr=0xFFF, if_rvalid+0x5FFF cycle 3.
//   3. dm write addr 0x014 wdata 0x0014 -> cycle 1 mem_en=1 mem_we=1 dm_gnt=1; dm_rvalid never; busy low at cycle 2.
//   4. if_req and dm_req (reads) held high, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I; each rdata to its port.
//   5. RD_LAT=3 read, rst pulsed during WAIT -> IDLE next cycle, no rvalid, rdata regs 0, subsequent read correct.
//   6. Back-to-back DM reads 0x000 then 0x7FF (RD_LAT=2) -> dm_rvalid cycles 4 and 9 with matching words; if_rdata unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle between the arbiter, its two requesters (fetch, data)
// and the shared single-port memory.
interface mem_port_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory between fetch and data ports: one access in
// flight, data priority, fetch forced after STARVE_MAX data wins.
module mem_port_arbiter #(
    parameter int AW         = 12,
    parameter int DW         = 16,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

    localparam logic [3:0] SMAX     = 4'(STARVE_MAX);
    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    state_e        state_q, state_d;
    logic          sel_if_q, sel_if_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [1:0]    lat_q, lat_d;
    logic [3:0]    starve_q, starve_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          pick_if;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_if_q   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_q      <= '0;
            starve_q   <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_if_q   <= sel_if_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lat_q      <= lat_d;
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_if_d   = sel_if_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lat_d      = lat_q;
        starve_d   = starve_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        pick_if    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    pick_if  = bus.if_req &&
                               (!bus.dm_req || starve_q == SMAX);
                    sel_if_d = pick_if;
                    state_d  = ACCESS;
                    if (pick_if) begin
                        we_d     = 1'b0;
                        addr_d   = bus.if_addr;
                        starve_d = '0;
                    end else begin
                        we_d    = bus.dm_we;
                        addr_d  = bus.dm_addr;
                        wdata_d = bus.dm_wdata;
                        // Count data wins only while fetch is kept waiting
                        if (!bus.if_req)
                            starve_d = '0;
                        else if (starve_q != SMAX)
                            starve_d = starve_q + 4'd1;
                    end
                end
            end
            ACCESS: begin
                lat_d   = '0;
                state_d = we_q ? IDLE : WAIT;
            end
            WAIT: begin
                if (lat_q == LAT_LAST) begin
                    if (sel_if_q) if_rdata_d = bus.mem_rdata;
                    else          dm_rdata_d = bus.mem_rdata;
                    state_d = RESP;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            RESP: state_d = IDLE;
        endcase
    end

    assign bus.mem_en    = (state_q == ACCESS);
    assign bus.mem_we    = bus.mem_en && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_gnt    = bus.mem_en && sel_if_q;
    assign bus.dm_gnt    = bus.mem_en && !sel_if_q;
    assign bus.if_rvalid = (state_q == RESP) && sel_if_q;
    assign bus.dm_rvalid = (state_q == RESP) && !sel_if_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
